ram_bist_ctrl: RTL

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_bist_pkg.sv | 20 ++
 rtl/ram_bist_if.sv | 14 +
 rtl/ram_bist_checker.sv | 59 +++++
 rtl/ram_bist_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and defaults for the RAM BIST controller: FSM state encoding
// and the default geometry and pattern seed.
package ram_bist_pkg;

    localparam int          ADDR_W_DEF = 6;
    localparam int          DATA_W_DEF = 4;
    localparam logic [3:0]  SEED_DEF   = 4'hA;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        RD0  = 3'd2,
        CHK0 = 3'd3,
        WR1  = 3'd4,
        RD1  = 3'd5,
        CHK1 = 3'd6,
        DONE = 3'd7
    } state_t;

endpackage

// File: rtl/ram_bist_if.sv
// RAM access bus between the BIST controller (master) and the RAM (slave).
interface ram_bist_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
);
    logic              Enable;
    logic              ReadWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;

    modport master (output Enable, ReadWrite, Address, DataIn, input DataOut);
    modport slave  (input Enable, ReadWrite, Address, DataIn, output DataOut);
endinterface

// File: rtl/ram_bist_checker.sv
// Read-data checker: registers each read's expectation, compares DataOut one
// cycle later, and keeps the saturating fail count and first-fail record.
module ram_bist_checker #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rd_vld,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic              rd_phase,
    input  logic [DATA_W-1:0] data_out,
    output logic              mismatch,
    output logic [7:0]        fail_count,
    output logic [ADDR_W-1:0] first_addr,
    output logic              first_phase
);
    logic              cmp_vld;
    logic [DATA_W-1:0] cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cmp_phase;

    assign mismatch = cmp_vld && (data_out != cmp_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_vld     <= 1'b0;
            cmp_exp     <= '0;
            cmp_addr    <= '0;
            cmp_phase   <= 1'b0;
            fail_count  <= '0;
            first_addr  <= '0;
            first_phase <= 1'b0;
        end else if (clr) begin
            cmp_vld     <= 1'b0;
            cmp_exp     <= '0;
            cmp_addr    <= '0;
            cmp_phase   <= 1'b0;
            fail_count  <= '0;
            first_addr  <= '0;
            first_phase <= 1'b0;
        end else begin
            cmp_vld   <= rd_vld;
            cmp_exp   <= rd_exp;
            cmp_addr  <= rd_addr;
            cmp_phase <= rd_phase;
            if (mismatch) begin
                if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
                // Count never returns to zero once non-zero, so zero marks "no fail yet".
                if (fail_count == 8'd0) begin
                    first_addr  <= cmp_addr;
                    first_phase <= cmp_phase;
                end
            end
        end
    end
endmodule

// File: rtl/ram_bist_ctrl.sv
// Two-phase RAM BIST: write/read-check a seeded address pattern, then its
// inverse; reports pass/fail, mismatch count and the first failing location.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter int                DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(SEED_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [7:0]        FailCount,
    output logic [ADDR_W-1:0] FirstFailAddr,
    output logic              FirstFailPhase,
    ram_bist_if.master        ram
);
    state_t            st, nxt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              en_q, rw_q, phase_q, busy_q, done_q, pass_q;
    logic              en_d, rw_d, phase_d;
    logic [DATA_W-1:0] din_q, din_d, exp_q, exp_d;
    logic              start_acc, last, mismatch;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic ph);
        logic [DATA_W-1:0] p;
        p = DATA_W'(a) ^ SEED;
        return ph ? ~p : p;
    endfunction

    assign last = (addr_q == '1);

    always_comb begin
        nxt       = st;
        start_acc = 1'b0;
        case (st)
            IDLE, DONE: if (Start) begin
                nxt       = WR0;
                start_acc = 1'b1;
            end
            WR0:     if (last) nxt = RD0;
            RD0:     if (last) nxt = CHK0;
            CHK0:    nxt = WR1;
            WR1:     if (last) nxt = RD1;
            RD1:     if (last) nxt = CHK1;
            CHK1:    nxt = DONE;
            default: nxt = IDLE;
        endcase

        // Counter advances only while issuing, wrapping to 0 into the next state.
        addr_d = '0;
        if (st inside {WR0, RD0, WR1, RD1}) addr_d = last ? '0 : addr_q + ADDR_W'(1);

        en_d    = nxt inside {WR0, RD0, WR1, RD1};
        rw_d    = nxt inside {WR0, WR1};
        phase_d = nxt inside {WR1, RD1};
        din_d   = rw_d ? pat(addr_d, phase_d) : '0;
        exp_d   = (en_d && !rw_d) ? pat(addr_d, phase_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            addr_q  <= '0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            din_q   <= '0;
            exp_q   <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            st      <= nxt;
            addr_q  <= en_d ? addr_d : '0;
            en_q    <= en_d;
            rw_q    <= rw_d;
            din_q   <= din_d;
            exp_q   <= exp_d;
            phase_q <= phase_d;
            busy_q  <= !(nxt inside {IDLE, DONE});
            done_q  <= (nxt == DONE);
            // The final phase-1 compare lands on the DONE entry edge, so fold it in.
            pass_q  <= (nxt == DONE) && (FailCount == 8'd0) && !mismatch;
        end
    end

    assign ram.Enable    = en_q;
    assign ram.ReadWrite = rw_q;
    assign ram.Address   = addr_q;
    assign ram.DataIn    = din_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Pass          = pass_q;

    ram_bist_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (start_acc),
        .rd_vld      (en_q && !rw_q),
        .rd_addr     (addr_q),
        .rd_exp      (exp_q),
        .rd_phase    (phase_q),
        .data_out    (ram.DataOut),
        .mismatch    (mismatch),
        .fail_count  (FailCount),
        .first_addr  (FirstFailAddr),
        .first_phase (FirstFailPhase)
    );
endmodule
